// File: rtl/norm_scan_sequencer.sv
// Multi-cycle mantissa normalizer: scans the operand one C-bit chunk per cycle
// from the MSB side, then left-aligns it in a single shift cycle.
module norm_scan_sequencer #(
    parameter int unsigned W = 112,
    parameter int unsigned C = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         io_in_valid,
    output logic         io_in_ready,
    input  logic [W-1:0] io_in_bits,
    input  logic         io_flush,
    output logic         io_out_valid,
    input  logic         io_out_ready,
    output logic [W-1:0] io_out_mant,
    output logic [6:0]   io_out_lz,
    output logic         io_out_zero,
    output logic         io_busy
);
    localparam int unsigned N  = W / C;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

    state_t        state, state_next;
    logic [W-1:0]  data, data_next;
    logic [W-1:0]  mant, mant_next;
    logic [KW-1:0] k, k_next;
    logic [6:0]    lz, lz_next;
    logic          zero, zero_next;

    logic [W-1:0]  aligned;
    logic [C-1:0]  chunk;
    logic          found;
    logic [6:0]    q_off;

    // Chunk k is brought to the top of the word, so the slice index stays constant.
    always_comb begin
        aligned = data << (k * C);
        chunk   = aligned[W-1 -: C];
        found   = 1'b0;
        q_off   = '0;
        for (int unsigned i = 0; i < C; i++) begin
            if (chunk[i]) begin
                found = 1'b1;
                q_off = 7'(C - 1 - i);
            end
        end
    end

    always_comb begin
        state_next = state;
        data_next  = data;
        k_next     = k;
        lz_next    = lz;
        mant_next  = mant;
        zero_next  = zero;
        case (state)
            IDLE: begin
                if (io_in_valid && io_in_ready) begin
                    data_next  = io_in_bits;
                    k_next     = '0;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (found) begin
                    lz_next    = 7'(k * C) + q_off;
                    state_next = SHIFT;
                end else if (k == KW'(N - 1)) begin
                    lz_next    = 7'(W);
                    zero_next  = 1'b1;
                    mant_next  = '0;
                    state_next = DONE;
                end else begin
                    k_next = k + 1'b1;
                end
            end
            SHIFT: begin
                mant_next  = data << lz;
                zero_next  = 1'b0;
                state_next = DONE;
            end
            DONE: begin
                if (io_out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Flush wins over a same-cycle acceptance: the operand is not captured.
        if (io_flush) begin
            state_next = IDLE;
            data_next  = data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            data  <= '0;
            k     <= '0;
            lz    <= '0;
            mant  <= '0;
            zero  <= 1'b0;
        end else begin
            state <= state_next;
            data  <= data_next;
            k     <= k_next;
            lz    <= lz_next;
            mant  <= mant_next;
            zero  <= zero_next;
        end
    end

    assign io_in_ready  = (state == IDLE) && !reset;
    assign io_out_valid = (state == DONE);
    assign io_busy      = (state != IDLE);
    assign io_out_mant  = mant;
    assign io_out_lz    = lz;
    assign io_out_zero  = zero;
endmodule

// File: tb/tb_norm_scan_sequencer.sv
// Scoreboard bench for norm_scan_sequencer: directed corner cases plus random
// operands, checked against a leading-one reference model.
module tb_norm_scan_sequencer;
    localparam int unsigned W = 112;
    localparam int unsigned C = 16;
    localparam int unsigned N = W / C;

    typedef struct {
        logic [W-1:0] mant;
        logic [6:0]   lz;
        logic         zero;
        int           exp_edge;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_bits = '0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_mant;
    logic [6:0]   out_lz;
    logic         out_zero;
    logic         busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    bit   seen_valid = 0;
    bit   check_idle = 0;
    bit   stall_mode = 0;
    int   valid_cycles = 0;

    norm_scan_sequencer #(.W(W), .C(C)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (in_valid),
        .io_in_ready  (in_ready),
        .io_in_bits   (in_bits),
        .io_flush     (flush),
        .io_out_valid (out_valid),
        .io_out_ready (out_ready),
        .io_out_mant  (out_mant),
        .io_out_lz    (out_lz),
        .io_out_zero  (out_zero),
        .io_busy      (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    // Reference: locate the highest set bit directly; chunk index sets the latency.
    function automatic exp_t model(input logic [W-1:0] x, input int acc);
        exp_t e;
        int   p = -1;
        for (int i = 0; i < int'(W); i++) if (x[i]) p = i;
        if (p < 0) begin
            e.mant = '0;
            e.lz = 7'(W);
            e.zero = 1'b1;
            e.exp_edge = acc + int'(N);
        end else begin
            e.lz = 7'(int'(W) - 1 - p);
            e.mant = x << (int'(W) - 1 - p);
            e.zero = 1'b0;
            e.exp_edge = acc + (int'(W) - 1 - p) / int'(C) + 2;
        end
        return e;
    endfunction

    // Monitor: compares every presented result against the scoreboard head.
    always @(negedge clock) begin
        if (reset) begin
            seen_valid = 0;
            check_idle = 0;
            valid_cycles = 0;
        end else begin
            if (check_idle) begin
                check_idle = 0;
                chk("idle_after_handshake_busy", busy, 0);
                chk("idle_after_handshake_in_ready", in_ready, 1);
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", out_valid, 0);
                end else begin
                    valid_cycles++;
                    if (!seen_valid) begin
                        seen_valid = 1;
                        chk("latency_edge", cyc, sb[0].exp_edge);
                    end
                    chk("out_mant", out_mant, sb[0].mant);
                    chk("out_lz", out_lz, sb[0].lz);
                    chk("out_zero", out_zero, sb[0].zero);
                    chk("in_ready_in_done", in_ready, 0);
                    chk("busy_in_done", busy, 1);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen_valid = 0;
                        valid_cycles = 0;
                        check_idle = 1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (stall_mode) out_ready = (valid_cycles >= 5);
            else            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_op(input logic [W-1:0] x, input bit track);
        int n = 0;
        in_valid = 1'b1;
        in_bits  = x;
        forever begin
            @(negedge clock);
            if (in_ready) break;
            n++;
            if (n > 500) begin
                chk("accept_timeout", in_ready, 1);
                break;
            end
        end
        if (in_ready && track) sb.push_back(model(x, cyc + 1));
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_bits  = rand_word();
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 500) begin
            @(posedge clock);
            #2;
            n++;
        end
        if (n >= 500) chk("done_timeout", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_mant"}, out_mant, 0);
        chk({tag, "_out_lz"}, out_lz, 0);
        chk({tag, "_out_zero"}, out_zero, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
    endtask

    initial begin
        logic [W-1:0] one;
        logic [W-1:0] mask;
        logic [W-1:0] x;
        int p;
        one = 1;

        #1 reset = 1'b1;
        #2 check_all_zero("reset");
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("in_ready_after_reset", in_ready, 1);
        chk("busy_after_reset", busy, 0);
        @(posedge clock);
        #1;

        send_op(one << (W - 1), 1);
        wait_done();
        send_op(one, 1);
        wait_done();
        send_op('0, 1);
        wait_done();

        stall_mode = 1;
        send_op(one << 50, 1);
        wait_done();
        stall_mode = 0;

        // Flush while chunk 3 is being examined; the result must never appear.
        send_op(one << 10, 0);
        repeat (3) @(posedge clock);
        #1 flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        @(negedge clock);
        chk("busy_after_flush", busy, 0);
        chk("in_ready_after_flush", in_ready, 1);
        @(posedge clock);
        #1;
        send_op(one << 15, 1);
        wait_done();

        // Reset during the SHIFT cycle of an operand.
        send_op(one << 100, 0);
        @(posedge clock);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("in_ready_after_midop_reset", in_ready, 1);
        @(posedge clock);
        #1;
        send_op(one << 100, 1);
        wait_done();

        for (int t = 0; t < 40; t++) begin
            p = int'($urandom_range(0, W));
            if (p == int'(W)) begin
                x = '0;
            end else begin
                mask = {W{1'b1}} >> (int'(W) - 1 - p);
                x = (rand_word() & mask) | (one << p);
            end
            send_op(x, 1);
        end
        wait_done();

        repeat (3) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/norm_scan_sequencer.md
NORM_SCAN_SEQUENCER -- requirements
Module: norm_scan_sequencer

Interface
REQ-001 SHALL have parameter W, default 112, meaning mantissa width in bits.
REQ-002 SHALL have parameter C, default 16, meaning scan chunk width in bits; W SHALL be a multiple of C, giving N = W/C chunks (N = 7 by default).
REQ-003 SHALL have port clock  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port io_in_valid  input  1  meaning the upstream operand is valid.
REQ-006 SHALL have port io_in_ready  output  1  meaning the block accepts an operand this cycle.
REQ-007 SHALL have port io_in_bits  input  W  meaning the unnormalized mantissa.
REQ-008 SHALL have port io_flush  input  1  meaning synchronous abort of any operation in flight.
REQ-009 SHALL have port io_out_valid  output  1  meaning the result is valid.
REQ-010 SHALL have port io_out_ready  input  1  meaning downstream accepts the result.
REQ-011 SHALL have port io_out_mant  output  W  meaning the normalized mantissa, with the leading one at bit W-1.
REQ-012 SHALL have port io_out_lz  output  7  meaning the leading-zero count, 0..W.
REQ-013 SHALL have port io_out_zero  output  1  meaning the operand was all zeros.
REQ-014 SHALL have port io_busy  output  1  meaning the state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, SCAN, SHIFT and DONE.
REQ-016 io_in_ready SHALL be high only in IDLE with reset low; acceptance (valid&ready) SHALL register io_in_bits, clear chunk index k to 0, and move to SCAN.
REQ-017 In SCAN, each cycle SHALL examine chunk k = bits [W-1-kC : W-C-kC], one chunk per cycle, MSB chunk first.
REQ-018 In SCAN, a nonzero chunk with highest set bit q (0..C-1) SHALL set lz = kC + (C-1-q) and move to SHIFT.
REQ-019 In SCAN, a zero chunk with k < N-1 SHALL increment k and remain in SCAN.
REQ-020 In SCAN, a zero chunk with k = N-1 SHALL set lz = W, zero = 1 and mant = 0, and move directly to DONE (no SHIFT).
REQ-021 SHIFT SHALL take one cycle: mant = data << lz, truncated to W bits, zero = 0; then move to DONE.
REQ-022 For nonzero input with highest set bit p, io_out_lz SHALL equal W-1-p, and io_out_mant[W-1] SHALL be 1.
REQ-023 Latency SHALL be as follows, with the accept edge as E0: a leading one in chunk k gives io_out_valid high after edge E(k+2); all-zero input gives io_out_valid high after edge E(N).
REQ-024 DONE SHALL assert io_out_valid and hold io_out_mant, io_out_lz and io_out_zero stable until io_out_ready; the cycle with valid&ready SHALL return to IDLE.
REQ-025 There SHALL be no same-cycle pass-through: io_in_ready SHALL be 0 in DONE even when io_out_ready = 1, so the next accept is at earliest one cycle after the output handshake.
REQ-026 io_flush SHALL force the next state to IDLE from any state, deasserting io_out_valid and discarding the result; io_flush SHALL override an input acceptance in the same cycle (the operand is not captured).
REQ-027 io_in_bits SHALL be ignored outside acceptance; the registered operand SHALL not change during SCAN or SHIFT.

Reset
REQ-028 Reset assertion SHALL immediately, regardless of clock, force: state IDLE, k = 0, io_out_valid = 0, io_out_mant = 0, io_out_lz = 0, io_out_zero = 0, io_busy = 0 and io_in_ready = 0.
REQ-029 Reset mid-operation SHALL abandon the operand; after deassertion no io_out_valid SHALL occur until a new acceptance, and io_in_ready SHALL rise in the first cycle with reset low.

Verification
REQ-030 Input bit 111 only: io_out_valid after E2, lz = 0, mant = 1<<111, zero = 0.
REQ-031 Input 0x1 (bit 0): scan reaches k = 6, io_out_valid after E8, lz = 111, mant = 1<<111.
REQ-032 Input all zeros: io_out_valid after E7, lz = 112, mant = 0, zero = 1, and the SHIFT state is never entered.
REQ-033 Input bit 50 set with io_out_ready held low 5 cycles: outputs stable with lz = 61, io_in_ready = 0 throughout, and the return to IDLE occurs on the ready cycle.
REQ-034 Assert io_flush in the SCAN cycle with k = 3 for input bit 10: no io_out_valid occurs, and the next operand 0x8000 is accepted and gives lz = 96.
REQ-035 Assert reset during SHIFT: outputs go to 0 asynchronously, and after release the next operand with bit 100 set gives lz = 11, valid after E2.
